// File: rtl/buffer_pkg.sv
// Shared definitions for the read/write line buffers: state encoding and lane mapping.
// Latency: none (types and constant functions only).
// Backpressure: not applicable.
package buffer_pkg;

    // Two-phase buffer: collect elements, then hold the line until memory takes it.
    typedef enum logic {
        FILL  = 1'b0,
        DRAIN = 1'b1
    } buf_state_t;

    // Number of element slots in one memory line.
    function automatic int max_elems(input int full_width, input int width);
        return full_width / width;
    endfunction

    // LSB of slot j inside a line; slot 0 is the most significant lane so that
    // the read and write buffers agree element-for-element.
    function automatic int lane_lsb(input int slot, input int full_width, input int width);
        return full_width - width * (slot + 1);
    endfunction

endpackage

// File: rtl/write_buffer.sv
// Packs WIDTH-bit elements into one FULL_WIDTH-bit line with a valid mask, then issues it as one write.
// Latency: line valid the cycle after the closing accept/flush; iready returns the cycle after the write handshake.
// Backpressure: iready is low for the whole DRAIN phase; line contents hold until wready is seen.
module write_buffer
    import buffer_pkg::*;
#(
    parameter int FULL_WIDTH = 512,
    parameter int WIDTH      = 64
) (
    input  logic                                        clk,
    input  logic                                        rst,
    input  logic                                        idata_valid,
    input  logic [WIDTH-1:0]                            idata,
    input  logic [7:0]                                  base,
    input  logic                                        flush,
    output logic                                        iready,
    output logic                                        wvalid,
    input  logic                                        wready,
    output logic [FULL_WIDTH-1:0]                       wdata,
    output logic [max_elems(FULL_WIDTH, WIDTH)-1:0]     wmask,
    output logic [7:0]                                  wcount
);

    localparam int         MAX_ELEMS = max_elems(FULL_WIDTH, WIDTH);
    localparam logic [7:0] NUM_SLOTS = 8'(MAX_ELEMS);
    localparam logic [7:0] LAST_SLOT = 8'(MAX_ELEMS - 1);

    buf_state_t               state;
    buf_state_t               state_nxt;
    logic [7:0]               wrptr;
    logic [7:0]               slot;
    logic                     accept;
    logic                     drain_done;
    logic [MAX_ELEMS-1:0]     lane_we;

    assign iready     = (state == FILL);
    assign wvalid     = (state == DRAIN);
    assign accept     = idata_valid & iready;
    assign drain_done = wvalid & wready;

    // Target slot: an empty buffer starts at base (out-of-range base falls back to 0), otherwise continue at wrptr.
    always_comb begin
        slot = wrptr;
        if (wcount == 8'd0) begin
            slot = (base < NUM_SLOTS) ? base : 8'd0;
        end
    end

    // Close the line on the last slot, or on flush when something is (or is about to be) buffered.
    always_comb begin
        state_nxt = state;
        case (state)
            FILL: begin
                if (accept && (slot == LAST_SLOT)) begin
                    state_nxt = DRAIN;
                end else if (flush && (accept || (wcount != 8'd0))) begin
                    state_nxt = DRAIN;
                end
            end
            DRAIN: begin
                if (wready) begin
                    state_nxt = FILL;
                end
            end
            default: state_nxt = FILL;
        endcase
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= FILL;
        end else begin
            state <= state_nxt;
        end
    end

    // Write pointer and element count: advance per accept, clear once the line is written.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wrptr  <= 8'd0;
            wcount <= 8'd0;
        end else if (drain_done) begin
            wrptr  <= 8'd0;
            wcount <= 8'd0;
        end else if (accept) begin
            wrptr  <= slot + 8'd1;
            wcount <= wcount + 8'd1;
        end
    end

    for (genvar j = 0; j < MAX_ELEMS; j++) begin : g_lane
        logic [WIDTH-1:0] lane_dat;
        logic             lane_vld;

        assign lane_we[j] = accept && (slot == 8'(j));

        // Per-slot storage: load on its write-enable, zero after the line leaves so unused lanes read 0.
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                lane_dat <= '0;
                lane_vld <= 1'b0;
            end else if (drain_done) begin
                lane_dat <= '0;
                lane_vld <= 1'b0;
            end else if (lane_we[j]) begin
                lane_dat <= idata;
                lane_vld <= 1'b1;
            end
        end

        assign wdata[lane_lsb(j, FULL_WIDTH, WIDTH) +: WIDTH] = lane_dat;
        assign wmask[MAX_ELEMS-1-j]                          = lane_vld;
    end

endmodule

// File: tb/tb_write_buffer.sv
module tb_write_buffer;

    typedef struct {
        logic [511:0] d;
        logic [7:0]   m;
        logic [7:0]   c;
    } line_t;

    logic         clk;
    logic         rst;
    logic         idata_valid;
    logic [63:0]  idata;
    logic [7:0]   base;
    logic         flush;
    logic         iready;
    logic         wvalid;
    logic         wready;
    logic [511:0] wdata;
    logic [7:0]   wmask;
    logic [7:0]   wcount;

    int    checks = 0;
    int    errors = 0;
    int    lines_seen = 0;
    line_t exp_q[$];

    write_buffer #(.FULL_WIDTH(512), .WIDTH(64)) dut (
        .clk         (clk),
        .rst         (rst),
        .idata_valid (idata_valid),
        .idata       (idata),
        .base        (base),
        .flush       (flush),
        .iready      (iready),
        .wvalid      (wvalid),
        .wready      (wready),
        .wdata       (wdata),
        .wmask       (wmask),
        .wcount      (wcount)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [511:0] act, input logic [511:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic push_line(input logic [511:0] d, input logic [7:0] m, input logic [7:0] c);
        line_t l;
        l.d = d;
        l.m = m;
        l.c = c;
        exp_q.push_back(l);
    endtask

    // Scoreboard monitor: every written line is compared against the next expected line.
    always @(negedge clk) begin
        if (!rst && wvalid && wready) begin
            lines_seen++;
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_line: got wmask %0h wcount %0d with no line expected", wmask, wcount);
            end else begin
                line_t e;
                e = exp_q.pop_front();
                chk("line_wdata",  wdata, e.d);
                chk("line_wmask",  512'(wmask), 512'(e.m));
                chk("line_wcount", 512'(wcount), 512'(e.c));
            end
        end
    end

    initial begin
        #50000;
        errors++;
        $display("FAIL watchdog: simulation time limit reached");
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $fatal(1, "watchdog");
    end

    initial begin
        rst         = 1'b1;
        idata_valid = 1'b0;
        idata       = '0;
        base        = '0;
        flush       = 1'b0;
        wready      = 1'b1;
        #3;
        chk("reset_iready", 512'(iready), 512'(1'b1));
        chk("reset_wvalid", 512'(wvalid), 512'(1'b0));
        chk("reset_wdata",  wdata, 512'h0);
        chk("reset_wmask",  512'(wmask), 512'h0);
        chk("reset_wcount", 512'(wcount), 512'h0);
        #4 rst = 1'b0;
        cycle();

        // Full line from slot 0.
        push_line({64'h11, 64'h22, 64'h33, 64'h44, 64'h55, 64'h66, 64'h77, 64'h88}, 8'hFF, 8'd8);
        for (int i = 0; i < 8; i++) begin
            chk("full_iready", 512'(iready), 512'(1'b1));
            idata_valid = 1'b1;
            idata       = 64'((i + 1) * 17);
            base        = 8'd0;
            cycle();
        end
        idata_valid = 1'b0;
        chk("full_wvalid_latency", 512'(wvalid), 512'(1'b1));
        chk("full_iready_drain",   512'(iready), 512'(1'b0));
        cycle();
        chk("full_wvalid_after_hs", 512'(wvalid), 512'(1'b0));
        chk("full_iready_after_hs", 512'(iready), 512'(1'b1));

        // Offset start at slot 3; base is ignored after the first element.
        push_line({192'h0, 64'hA1, 64'hA2, 64'hA3, 64'hA4, 64'hA5}, 8'h1F, 8'd5);
        for (int i = 0; i < 5; i++) begin
            idata_valid = 1'b1;
            idata       = 64'(8'hA1 + i);
            base        = (i == 0) ? 8'd3 : 8'd1;
            cycle();
        end
        chk("offset_closes_on_last", 512'(wvalid), 512'(1'b1));
        idata_valid = 1'b0;
        cycle();
        chk("offset_wvalid_after_hs", 512'(wvalid), 512'(1'b0));

        // Partial line closed by flush on the second element.
        push_line({64'hB1, 64'hB2, 384'h0}, 8'hC0, 8'd2);
        idata_valid = 1'b1;
        idata       = 64'hB1;
        base        = 8'd0;
        cycle();
        chk("partial_not_closed", 512'(wvalid), 512'(1'b0));
        idata = 64'hB2;
        flush = 1'b1;
        cycle();
        idata_valid = 1'b0;
        flush       = 1'b0;
        chk("partial_wvalid", 512'(wvalid), 512'(1'b1));
        cycle();
        chk("partial_wvalid_after_hs", 512'(wvalid), 512'(1'b0));

        // Flush with an empty buffer does nothing.
        flush = 1'b1;
        cycle();
        flush = 1'b0;
        chk("empty_flush_wvalid", 512'(wvalid), 512'(1'b0));
        chk("empty_flush_iready", 512'(iready), 512'(1'b1));
        cycle();
        chk("empty_flush_wvalid2", 512'(wvalid), 512'(1'b0));

        // Backpressure: line held for 10 cycles while the producer keeps offering C4 with flush.
        wready = 1'b0;
        push_line({64'hC1, 64'hC2, 64'hC3, 320'h0}, 8'hE0, 8'd3);
        for (int i = 0; i < 3; i++) begin
            idata_valid = 1'b1;
            idata       = 64'(8'hC1 + i);
            base        = 8'd0;
            flush       = (i == 2);
            cycle();
        end
        idata = 64'hC4;
        flush = 1'b1;
        for (int i = 0; i < 10; i++) begin
            chk("bp_iready", 512'(iready), 512'(1'b0));
            chk("bp_wvalid", 512'(wvalid), 512'(1'b1));
            chk("bp_wdata",  wdata, {64'hC1, 64'hC2, 64'hC3, 320'h0});
            chk("bp_wmask",  512'(wmask), 512'(8'hE0));
            chk("bp_wcount", 512'(wcount), 512'(8'd3));
            cycle();
        end
        push_line({64'hC4, 448'h0}, 8'h80, 8'd1);
        wready = 1'b1;
        cycle();
        chk("bp_hs_wvalid", 512'(wvalid), 512'(1'b0));
        chk("bp_hs_iready", 512'(iready), 512'(1'b1));
        cycle();
        idata_valid = 1'b0;
        flush       = 1'b0;
        chk("bp_held_elem_wvalid", 512'(wvalid), 512'(1'b1));
        cycle();
        chk("bp_held_elem_done", 512'(wvalid), 512'(1'b0));

        // Asynchronous reset in DRAIN discards the pending line.
        wready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            idata_valid = 1'b1;
            idata       = 64'(8'hD1 + i);
            base        = 8'd0;
            flush       = (i == 4);
            cycle();
        end
        idata_valid = 1'b0;
        flush       = 1'b0;
        chk("rst_pre_wvalid", 512'(wvalid), 512'(1'b1));
        chk("rst_pre_wcount", 512'(wcount), 512'(8'd5));
        #2 rst = 1'b1;
        #1;
        chk("rst_async_wvalid", 512'(wvalid), 512'(1'b0));
        chk("rst_async_wmask",  512'(wmask), 512'h0);
        chk("rst_async_wcount", 512'(wcount), 512'h0);
        chk("rst_async_wdata",  wdata, 512'h0);
        chk("rst_async_iready", 512'(iready), 512'(1'b1));
        #3 rst = 1'b0;
        wready = 1'b1;
        push_line({64'hE1, 448'h0}, 8'h80, 8'd1);
        idata_valid = 1'b1;
        idata       = 64'hE1;
        base        = 8'd9;
        flush       = 1'b1;
        cycle();
        idata_valid = 1'b0;
        flush       = 1'b0;
        chk("base9_wvalid", 512'(wvalid), 512'(1'b1));
        cycle();
        chk("base9_done", 512'(wvalid), 512'(1'b0));

        cycle();
        chk("queue_drained", 512'(exp_q.size()), 512'h0);
        chk("lines_written", 512'(lines_seen), 512'd6);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/write_buffer.md
# write_buffer

Write-side counterpart of the read buffer. Accepts WIDTH-bit elements one per handshake, packs them into a FULL_WIDTH-bit line with a per-element valid mask, and issues the line as one wide write when the last slot fills or on flush. Sits between the PageRank compute datapath and the memory write port. Lane layout matches the read buffer so a written line reads back element-for-element.

## Interface
- FULL_WIDTH, 512, width of one memory line
- WIDTH, 64, width of one element; MAX_ELEMS = FULL_WIDTH/WIDTH (8)
- clk  in  1  single clock, all state on posedge
- rst  in  1  asynchronous, active-high reset
- idata_valid  in  1  producer offers idata
- idata  in  WIDTH  element to pack
- base  in  8  start slot of a new line, sampled only on the first accept into an empty buffer
- flush  in  1  close the current partial line
- iready  out  1  buffer accepts an element this cycle
- wvalid  out  1  wdata/wmask/wcount hold a line to write
- wready  in  1  memory side accepts the line
- wdata  out  FULL_WIDTH  packed line
- wmask  out  MAX_ELEMS  per-slot valid bits
- wcount  out  8  number of valid elements in the line

## Operation
- Two states: FILL (iready=1, wvalid=0) and DRAIN (iready=0, wvalid=1).
- Accept = idata_valid & iready. On accept, idata goes to slot wrptr, wmask bit for that slot is set, wcount increments, wrptr increments.
- First accept into an empty buffer (wcount==0): slot = base if base < MAX_ELEMS, else 0. Later accepts use wrptr.
- Slot j occupies wdata[FULL_WIDTH-1-WIDTH*j -: WIDTH]. Its mask bit is wmask[MAX_ELEMS-1-j]. Slot 0 is the most significant lane.
- FILL→DRAIN when an accept writes slot MAX_ELEMS-1, or when flush=1 and the buffer is non-empty after this cycle's accept.
- An accept and a flush in the same cycle: the element is included, then DRAIN.
- A flush with an empty buffer and no accept is ignored.
- flush is sampled only in FILL and has no effect in DRAIN. It is not sticky.
- DRAIN→FILL on wready=1. On that edge, wmask, wcount and wdata are cleared, and wrptr is set to 0.
- Unwritten slots are always 0 in wdata.
- wrptr and wcount are 8-bit and never exceed MAX_ELEMS. No wrap can occur because a line closes at the last slot.

## Timing
- Reset values: state FILL, iready=1, wvalid=0, wdata=0, wmask=0, wcount=0, wrptr=0.
- Reset asserted mid-DRAIN discards the pending line. wvalid drops asynchronously.
- Latency: the line-closing accept or flush at edge N gives wvalid=1 from the cycle after edge N.
- wdata, wmask and wcount are stable while wvalid=1 and wready=0.
- Handshake at edge M gives wvalid=0 and iready=1 in the cycle after M. No element is accepted in the handshake cycle.
- Peak throughput is one full line per MAX_ELEMS+1 cycles.
- wvalid does not depend combinationally on wready. iready depends only on state.

## Structure
- Shared package buffer_pkg holds MAX_ELEMS derivation, the FILL/DRAIN state encoding, and the slot-to-lane index function. The read buffer uses the same index function.
- Single module with no sub-module. Lane write-enables come from a generate loop over slots.

## Test plan
- Full line, base=0: accept 8 elements 0x11..0x88 back-to-back with wready=1. Expect wvalid one cycle after the 8th accept, wmask=0xFF, wcount=8, wdata[511:448]=0x11, wdata[63:0]=0x88. Expect iready=1 the next cycle.
- Offset start, base=3: accept 5 elements. Expect the line to close on slot 7, wmask=0x1F, wcount=5, and the first element in slot 3 (bits 319:256).
- Partial flush: accept 2 elements with flush asserted on the 2nd. Expect wmask=0xC0, wcount=2, lower 6 lanes zero.
- Empty flush: flush with no elements and no accept. Expect wvalid to stay 0 and state to remain FILL.
- Backpressure: hold wready=0 for 10 cycles in DRAIN while driving idata_valid=1 and flush. Expect iready=0, wdata/wmask unchanged, and no element lost.
- Async reset during DRAIN with wcount=5. Expect wvalid=0, wmask=0, wcount=0 immediately. After release, base=9 maps the first element to slot 0.
